// File: rtl/rdma_sq_arbiter.sv
// rdma_sq_arbiter
//   Shares one RDMA send-queue command channel among N_REQ requesters (aclk
//   domain). Round-robin grant, requester ID stamped into the outgoing command,
//   per-requester in-flight cap tracked from returned acks, and a flush/drain
//   handshake for teardown.
//
// Ports
//   aclk, aresetn           clock, synchronous active-low reset
//   s_sq_valid/ready/data   per-requester command inputs (ready is one-hot or 0)
//   m_sq_valid/ready/data   registered command toward the SQ clock crossing
//   s_ack_valid/ready/data  ack words returning from the crossing
//   m_ack_valid             one-cycle per-requester ack notify
//   flush, flush_done       drain request (level) / completion pulse
//   ack_err                 sticky: ack for an unknown or idle requester
//   stat_grants             per-requester 32-bit grant counters
//
// Optional feature macro: RDMA_SQ_ARB_STATS_EN enables the grant counters;
// without it stat_grants is tied to zero.

// Per-requester in-flight counter and ack notify.
module rdma_sq_arb_lane #(
    parameter int CNT_W           = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             grant,
    input  logic             ack_hit,
    output logic [CNT_W-1:0] outst,
    output logic             room,
    output logic             ack_bad,
    output logic             ack_notify
);
    logic dec;

    assign room    = outst < CNT_W'(MAX_OUTSTANDING);
    assign dec     = ack_hit && (outst != '0);
    assign ack_bad = ack_hit && (outst == '0);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            outst      <= '0;
            ack_notify <= 1'b0;
        end else begin
            ack_notify <= dec;
            // a grant and a valid ack in the same cycle cancel out
            if (grant && !dec)
                outst <= outst + 1'b1;
            else if (!grant && dec)
                outst <= outst - 1'b1;
        end
    end
endmodule

module rdma_sq_arbiter #(
    parameter int N_REQ           = 4,
    parameter int SQ_BITS         = 256,
    parameter int ACK_BITS        = 32,
    parameter int ID_LSB          = 0,
    parameter int ACK_ID_LSB      = 0,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [N_REQ-1:0]         s_sq_valid,
    output logic [N_REQ-1:0]         s_sq_ready,
    input  logic [N_REQ*SQ_BITS-1:0] s_sq_data,
    output logic                     m_sq_valid,
    input  logic                     m_sq_ready,
    output logic [SQ_BITS-1:0]       m_sq_data,
    input  logic                     s_ack_valid,
    output logic                     s_ack_ready,
    input  logic [ACK_BITS-1:0]      s_ack_data,
    output logic [N_REQ-1:0]         m_ack_valid,
    input  logic                     flush,
    output logic                     flush_done,
    output logic                     ack_err,
    output logic [N_REQ*32-1:0]      stat_grants
);
    localparam int ID_BITS = $clog2(N_REQ);
    localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {RUN, DRAIN, DONE, IDLE_F} state_t;

    state_t                        state_q, state_d;
    logic [ID_BITS-1:0]            ptr;
    logic [N_REQ-1:0]              eligible, room, ack_hit, ack_bad, grant_oh;
    logic [N_REQ-1:0][CNT_W-1:0]   outst;
    logic                          out_free, gnt_vld, drained;
    logic [ID_BITS-1:0]            gnt_idx;
    logic [SQ_BITS-1:0]            sel_data;
    logic                          ack_fire, ack_oob;
    logic [ID_BITS-1:0]            ack_id;

    // position k steps after the RR pointer, modulo N_REQ
    function automatic logic [ID_BITS-1:0] rr_pos(input logic [ID_BITS-1:0] base,
                                                  input int unsigned k);
        int unsigned s;
        s = (32'(base) + k) % N_REQ;
        return ID_BITS'(s);
    endfunction

    // Ack channel is always open outside reset.
    assign s_ack_ready = aresetn;
    assign ack_fire    = s_ack_valid && s_ack_ready;
    assign ack_id      = s_ack_data[ACK_ID_LSB +: ID_BITS];
    assign ack_oob     = ack_fire && (32'(ack_id) >= N_REQ);

    assign out_free = !m_sq_valid || m_sq_ready;

    // Scan from the far end back toward the pointer so the last hit wins,
    // i.e. the first eligible index at or after the pointer.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (eligible[rr_pos(ptr, k)]) begin
                gnt_vld = 1'b1;
                gnt_idx = rr_pos(ptr, k);
            end
        end
        gnt_vld = gnt_vld && out_free;
    end

    always_comb begin
        sel_data = s_sq_data[gnt_idx*SQ_BITS +: SQ_BITS];
        sel_data[ID_LSB +: ID_BITS] = gnt_idx;
    end

    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        // aresetn gate keeps s_sq_ready low while reset is held
        assign eligible[i] = s_sq_valid[i] && room[i] && (state_q == RUN) && aresetn;
        assign grant_oh[i] = gnt_vld && (gnt_idx == ID_BITS'(i));
        assign ack_hit[i]  = ack_fire && (ack_id == ID_BITS'(i));

        rdma_sq_arb_lane #(
            .CNT_W          (CNT_W),
            .MAX_OUTSTANDING(MAX_OUTSTANDING)
        ) u_lane (
            .aclk      (aclk),
            .aresetn   (aresetn),
            .grant     (grant_oh[i]),
            .ack_hit   (ack_hit[i]),
            .outst     (outst[i]),
            .room      (room[i]),
            .ack_bad   (ack_bad[i]),
            .ack_notify(m_ack_valid[i])
        );
    end

    assign s_sq_ready = grant_oh;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_sq_valid <= 1'b0;
            m_sq_data  <= '0;
            ptr        <= '0;
            ack_err    <= 1'b0;
        end else begin
            if (gnt_vld) begin
                m_sq_valid <= 1'b1;
                m_sq_data  <= sel_data;
                ptr        <= (gnt_idx == ID_BITS'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end else if (m_sq_ready) begin
                m_sq_valid <= 1'b0;
            end
            if (ack_oob || (|ack_bad))
                ack_err <= 1'b1;
        end
    end

    // Drain completes once nothing is in flight and nothing is held.
    assign drained = (outst == '0) && !m_sq_valid;

    always_ff @(posedge aclk) begin
        if (!aresetn) state_q <= RUN;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        flush_done = 1'b0;
        unique case (state_q)
            RUN:    if (flush) state_d = DRAIN;
            DRAIN:  if (drained) state_d = DONE;
            DONE: begin
                flush_done = 1'b1;
                state_d    = IDLE_F;
            end
            IDLE_F: if (!flush) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

`ifdef RDMA_SQ_ARB_STATS_EN
    for (genvar i = 0; i < N_REQ; i++) begin : g_stat
        logic [31:0] cnt;
        always_ff @(posedge aclk) begin
            if (!aresetn)         cnt <= '0;
            else if (grant_oh[i]) cnt <= cnt + 32'd1;
        end
        assign stat_grants[i*32 +: 32] = cnt;
    end
`else
    assign stat_grants = '0;
`endif

endmodule

// File: tb/tb_rdma_sq_arbiter.sv
module tb_rdma_sq_arbiter;
    localparam int N    = 4;
    localparam int SQB  = 64;
    localparam int AB   = 32;
    localparam int MAXO = 8;
    localparam int NCYC = 1400;

    logic               aclk = 1'b0;
    logic               aresetn = 1'b0;
    logic [N-1:0]       s_sq_valid = '0;
    logic [N-1:0]       s_sq_ready;
    logic [N*SQB-1:0]   s_sq_data = '0;
    logic               m_sq_valid;
    logic               m_sq_ready = 1'b0;
    logic [SQB-1:0]     m_sq_data;
    logic               s_ack_valid = 1'b0;
    logic               s_ack_ready;
    logic [AB-1:0]      s_ack_data = '0;
    logic [N-1:0]       m_ack_valid;
    logic               flush = 1'b0;
    logic               flush_done;
    logic               ack_err;
    logic [N*32-1:0]    stat_grants;

    always #5 aclk = ~aclk;

    rdma_sq_arbiter #(
        .N_REQ(N), .SQ_BITS(SQB), .ACK_BITS(AB), .ID_LSB(0), .ACK_ID_LSB(0),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_sq_valid(s_sq_valid), .s_sq_ready(s_sq_ready), .s_sq_data(s_sq_data),
        .m_sq_valid(m_sq_valid), .m_sq_ready(m_sq_ready), .m_sq_data(m_sq_data),
        .s_ack_valid(s_ack_valid), .s_ack_ready(s_ack_ready), .s_ack_data(s_ack_data),
        .m_ack_valid(m_ack_valid), .flush(flush), .flush_done(flush_done),
        .ack_err(ack_err), .stat_grants(stat_grants)
    );

    typedef struct {
        logic [N-1:0] ackv;
        logic         err;
        logic         done;
    } rec_t;

    logic [SQB-1:0] exp_q[$];   // commands granted, not yet taken by the crossing
    rec_t           rec_q[$];   // per-cycle expected ack / status outputs

    int errors = 0;
    int checks = 0;

    // reference state
    int   outst[N];
    int   grants[N];
    int   ptr   = 0;
    int   phase = 0;            // 0 run, 1 drain, 2 done, 3 idle-after-flush
    logic err_m = 1'b0;
    bit   drv_done = 1'b0;
    bit   held;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic driver();
        bit bad_done = 0;
        for (int c = 0; c < NCYC; c++) begin
            int seg, vp, rp, ap, g, aid, r;
            bit fl, drained;
            logic [N-1:0] exp_rdy, ackv;
            logic [SQB-1:0] cmd;
            @(negedge aclk);
            seg = c / 200;
            vp = (seg == 0 || seg == 2) ? 100 : 60;
            rp = (seg == 0 || seg == 2) ? 100 : ((seg == 3) ? 40 : 70);
            ap = (seg == 0) ? 95 : ((seg == 2) ? 3 : 40);
            fl = 0;
            if (seg == 4)      fl = (c % 200) < 120;
            else if (seg == 5) fl = ($urandom % 100) < 15;
            if (c >= NCYC - 40) begin fl = 0; ap = 90; rp = 100; end
            for (int i = 0; i < N; i++) begin
                s_sq_valid[i] = ($urandom % 100) < vp;
                s_sq_data[i*SQB +: SQB] = {$urandom, $urandom};
            end
            m_sq_ready = ($urandom % 100) < rp;
            flush = fl;
            // acks go only to requesters with something in flight, except one
            // deliberate ack to an idle requester late in the run
            aid = -1;
            if (!bad_done && c >= 1300) begin
                for (int j = 0; j < N; j++) if (aid < 0 && outst[j] == 0) aid = j;
                if (aid >= 0) bad_done = 1;
            end else if (($urandom % 100) < ap) begin
                r = $urandom % N;
                for (int k = 0; k < N; k++)
                    if (aid < 0 && outst[(r + k) % N] > 0) aid = (r + k) % N;
            end
            s_ack_data  = $urandom;
            s_ack_valid = (aid >= 0);
            if (aid >= 0) s_ack_data[1:0] = 2'(aid);
            #1 held = (exp_q.size() != 0);
            #2;
            g = -1;
            if (phase == 0 && (!held || m_sq_ready))
                for (int k = 0; k < N; k++)
                    if (g < 0 && s_sq_valid[(ptr + k) % N] && outst[(ptr + k) % N] < MAXO)
                        g = (ptr + k) % N;
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("s_sq_ready", 64'(s_sq_ready), 64'(exp_rdy));
            drained = !held;
            for (int j = 0; j < N; j++) if (outst[j] != 0) drained = 0;
            ackv = '0;
            if (aid >= 0) begin
                if (outst[aid] == 0) err_m = 1'b1;
                else                 ackv[aid] = 1'b1;
            end
            if (g >= 0) begin
                cmd = s_sq_data[g*SQB +: SQB];
                cmd[1:0] = 2'(g);
                exp_q.push_back(cmd);
                ptr = (g + 1) % N;
                grants[g]++;
                outst[g]++;
            end
            if (aid >= 0 && ackv[aid]) outst[aid]--;
            case (phase)
                0: if (flush) phase = 1;
                1: if (drained) phase = 2;
                2: phase = 3;
                default: if (!flush) phase = 0;
            endcase
            rec_q.push_back('{ackv: ackv, err: err_m, done: (phase == 2)});
        end
        drv_done = 1;
    endtask

    task automatic monitor();
        while (!drv_done) begin
            rec_t rc;
            @(negedge aclk);
            #2;
            chk("m_sq_valid", 64'(m_sq_valid), 64'(exp_q.size() != 0));
            if (m_sq_valid && m_sq_ready) begin
                if (exp_q.size() == 0) chk("unexpected_cmd", 64'(m_sq_data), 64'(0));
                else                   chk("m_sq_data", m_sq_data, exp_q.pop_front());
            end
            chk("s_ack_ready", 64'(s_ack_ready), 64'(1));
            if (rec_q.size() == 0) begin
                chk("rec_queue_empty", 64'(rec_q.size()), 64'(1));
            end else begin
                rc = rec_q.pop_front();
                chk("m_ack_valid", 64'(m_ack_valid), 64'(rc.ackv));
                chk("ack_err", 64'(ack_err), 64'(rc.err));
                chk("flush_done", 64'(flush_done), 64'(rc.done));
            end
        end
    endtask

    initial begin
        logic [SQB-1:0] c0;
        for (int i = 0; i < N; i++) begin outst[i] = 0; grants[i] = 0; end
        repeat (3) @(negedge aclk);
        #1;
        chk("rst_m_sq_valid", 64'(m_sq_valid), 64'(0));
        chk("rst_m_sq_data", m_sq_data, 64'(0));
        chk("rst_s_sq_ready", 64'(s_sq_ready), 64'(0));
        chk("rst_s_ack_ready", 64'(s_ack_ready), 64'(0));
        chk("rst_ack_err", 64'(ack_err), 64'(0));
        aresetn = 1'b1;
        rec_q.push_back('{ackv: '0, err: 1'b0, done: 1'b0});
        fork
            driver();
            monitor();
        join

        for (int i = 0; i < N; i++) begin
`ifdef RDMA_SQ_ARB_STATS_EN
            chk("stat_grants", 64'(stat_grants[i*32 +: 32]), 64'(grants[i]));
`else
            chk("stat_grants_off", 64'(stat_grants[i*32 +: 32]), 64'(0));
`endif
        end

        // reset in the middle of a stall
        @(negedge aclk);
        s_sq_valid = '1; m_sq_ready = 1'b0; s_ack_valid = 1'b0; flush = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b0;
        #1 chk("rst2_s_sq_ready_low", 64'(s_sq_ready), 64'(0));
        @(negedge aclk);
        #1;
        chk("rst2_m_sq_valid", 64'(m_sq_valid), 64'(0));
        chk("rst2_m_sq_data", m_sq_data, 64'(0));
        chk("rst2_ack_err", 64'(ack_err), 64'(0));
        chk("rst2_m_ack_valid", 64'(m_ack_valid), 64'(0));
        chk("rst2_flush_done", 64'(flush_done), 64'(0));
        chk("rst2_stat_grants", 64'(stat_grants[63:0]) | 64'(stat_grants[127:64]), 64'(0));
        aresetn = 1'b1;
        m_sq_ready = 1'b1;
        #1;
        chk("rst2_ptr_grant0", 64'(s_sq_ready), 64'(1));
        c0 = s_sq_data[SQB-1:0];
        c0[1:0] = 2'd0;
        @(negedge aclk);
        #1;
        chk("rst2_first_valid", 64'(m_sq_valid), 64'(1));
        chk("rst2_first_data", m_sq_data, c0);
        chk("rst2_next_grant1", 64'(s_sq_ready), 64'(2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
